// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and constants for the VRAM arbiter
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_GFX
    } owner_t;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_ACTIVE
    } fetch_state_t;

    localparam logic [3:0] MASK_ALL = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    // Pops on an empty FIFO are ignored so the head word stays put; a push
    // into a full FIFO is only accepted when a pop frees a slot that cycle.
    assign w_pop   = pop_i && (r_count != '0);
    assign w_push  = push_i && ((r_count != COUNT_FULL) || w_pop);
    assign head_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    // Storage write; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM arbiter between display prefetch and graphite core
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              disp_start_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    input  logic [LEN_W-1:0]  disp_len_i,
    input  logic              disp_rd_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_empty_o,
    output logic              disp_underrun_o,
    input  logic              gfx_sel_i,
    input  logic              gfx_wr_i,
    input  logic [3:0]        gfx_mask_i,
    input  logic [ADDR_W-1:0] gfx_addr_i,
    input  logic [DATA_W-1:0] gfx_data_i,
    output logic              gfx_grant_o,
    output logic              gfx_rvalid_o,
    output logic [DATA_W-1:0] gfx_data_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [3:0]        vram_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  w_rem_nxt;
    logic              r_disp_inflight;
    logic              r_gfx_rd_inflight;
    logic              r_underrun;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credits;
    logic              w_empty;
    logic              w_elig;
    logic              w_urgent;
    logic              w_drop;
    logic              w_push;
    owner_t            w_owner;

    // Credits reserve a FIFO slot for the display read still on its way back.
    assign w_credits = {1'b0, w_count} + {{CNT_W{1'b0}}, r_disp_inflight};
    // The display never issues in a start cycle, so the new burst begins next cycle.
    assign w_elig    = (r_state == FETCH_ACTIVE) && !disp_start_i
                       && (w_credits < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_urgent  = w_elig && (w_credits < (CNT_W + 1)'(LOW_WM));
    // A return belonging to a burst that is being restarted must not be kept.
    assign w_drop    = r_disp_inflight && disp_start_i;
    assign w_push    = r_disp_inflight && !w_drop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_disp_fifo (
        .clk         (clk),
        .reset_i     (reset_i),
        .flush_i     (disp_start_i),
        .push_i      (w_push),
        .push_data_i (vram_data_i),
        .pop_i       (disp_rd_i),
        .head_o      (disp_data_o),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    assign disp_empty_o    = w_empty;
    assign disp_underrun_o = r_underrun;
    assign gfx_rvalid_o    = r_gfx_rd_inflight;
    assign gfx_data_o      = r_gfx_rd_inflight ? vram_data_i : '0;

    // Per-cycle owner: starving display first, then graphite, then display refill.
    always_comb begin
        w_owner = OWN_NONE;
        if (reset_i) begin
            w_owner = OWN_NONE;
        end else if (w_urgent) begin
            w_owner = OWN_DISP;
        end else if (gfx_sel_i) begin
            w_owner = OWN_GFX;
        end else if (w_elig) begin
            w_owner = OWN_DISP;
        end
    end

    // Drive the VRAM port from whichever requester owns this cycle.
    always_comb begin
        vram_sel_o  = 1'b0;
        vram_wr_o   = 1'b0;
        vram_mask_o = MASK_ALL;
        vram_addr_o = '0;
        vram_data_o = '0;
        gfx_grant_o = 1'b0;
        case (w_owner)
            OWN_DISP: begin
                vram_sel_o  = 1'b1;
                vram_addr_o = r_ptr;
            end
            OWN_GFX: begin
                vram_sel_o  = 1'b1;
                vram_wr_o   = gfx_wr_i;
                vram_mask_o = gfx_mask_i;
                vram_addr_o = gfx_addr_i;
                vram_data_o = gfx_data_i;
                gfx_grant_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch state register with burst pointer and remaining length.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state     <= FETCH_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

    // Fetch next state: a start reloads the burst, each display issue consumes a word.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_remaining;
        if (disp_start_i) begin
            w_ptr_nxt   = disp_addr_i;
            w_rem_nxt   = disp_len_i;
            w_state_nxt = (disp_len_i != '0) ? FETCH_ACTIVE : FETCH_IDLE;
        end else if (w_owner == OWN_DISP) begin
            w_ptr_nxt = r_ptr + 1'b1;
            w_rem_nxt = r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
                w_state_nxt = FETCH_IDLE;
            end
        end
    end

    // Remember what was issued so next cycle's read data reaches the right requester.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_disp_inflight   <= 1'b0;
            r_gfx_rd_inflight <= 1'b0;
            r_underrun        <= 1'b0;
        end else begin
            r_disp_inflight   <= (w_owner == OWN_DISP);
            r_gfx_rd_inflight <= (w_owner == OWN_GFX) && !gfx_wr_i;
            if (disp_start_i) begin
                r_underrun <= 1'b0;
            end else if (disp_rd_i && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard testbench for vram_arbiter
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        disp_start_i;
    logic [15:0] disp_addr_i;
    logic [11:0] disp_len_i;
    logic        disp_rd_i;
    logic [15:0] disp_data_o;
    logic        disp_empty_o;
    logic        disp_underrun_o;
    logic        gfx_sel_i;
    logic        gfx_wr_i;
    logic [3:0]  gfx_mask_i;
    logic [15:0] gfx_addr_i;
    logic [15:0] gfx_data_i;
    logic        gfx_grant_o;
    logic        gfx_rvalid_o;
    logic [15:0] gfx_data_o;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [3:0]  vram_mask_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .LEN_W(12), .FIFO_DEPTH(16), .LOW_WM(4)
    ) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .disp_start_i    (disp_start_i),
        .disp_addr_i     (disp_addr_i),
        .disp_len_i      (disp_len_i),
        .disp_rd_i       (disp_rd_i),
        .disp_data_o     (disp_data_o),
        .disp_empty_o    (disp_empty_o),
        .disp_underrun_o (disp_underrun_o),
        .gfx_sel_i       (gfx_sel_i),
        .gfx_wr_i        (gfx_wr_i),
        .gfx_mask_i      (gfx_mask_i),
        .gfx_addr_i      (gfx_addr_i),
        .gfx_data_i      (gfx_data_i),
        .gfx_grant_o     (gfx_grant_o),
        .gfx_rvalid_o    (gfx_rvalid_o),
        .gfx_data_o      (gfx_data_o),
        .vram_sel_o      (vram_sel_o),
        .vram_wr_o       (vram_wr_o),
        .vram_mask_o     (vram_mask_o),
        .vram_addr_o     (vram_addr_o),
        .vram_data_o     (vram_data_o),
        .vram_data_i     (vram_data_i)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] r_vram_q;
    logic [15:0] exp_gfx[$];
    logic [15:0] exp_disp[$];
    logic [15:0] exp_daddr[$];

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [3:0] m);
        logic [15:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*4 +: 4] = n[b*4 +: 4];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // VRAM: one-cycle read latency, nibble write mask.
    always @(posedge clk) begin
        r_vram_q <= mem[vram_addr_o];
        if (vram_sel_o && vram_wr_o) begin
            mem[vram_addr_o] = merge(mem[vram_addr_o], vram_data_o, vram_mask_o);
        end
    end
    assign vram_data_i = r_vram_q;

    // Monitor: compares DUT outputs against the expectations queued by stimulus.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (gfx_rvalid_o) begin
                if (exp_gfx.size() == 0) fail_now("gfx_rvalid_unexpected");
                else check("gfx_rdata", 32'(gfx_data_o), 32'(exp_gfx.pop_front()));
            end
            if (gfx_grant_o) begin
                check("grant_has_req", 32'(gfx_sel_i), 32'd1);
                check("gfx_addr_pass", 32'(vram_addr_o), 32'(gfx_addr_i));
            end else if (vram_sel_o) begin
                check("disp_read_only", 32'(vram_wr_o), 32'd0);
                if (exp_daddr.size() == 0) fail_now("disp_issue_unexpected");
                else check("disp_addr", 32'(vram_addr_o), 32'(exp_daddr.pop_front()));
            end
            if (disp_rd_i && !disp_empty_o) begin
                if (exp_disp.size() == 0) fail_now("disp_pop_unexpected");
                else check("disp_data", 32'(disp_data_o), 32'(exp_disp.pop_front()));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gfx_req(input logic wr, input logic [3:0] m, input logic [15:0] a,
                           input logic [15:0] d, output int waited);
        waited     = 0;
        gfx_sel_i  = 1'b1;
        gfx_wr_i   = wr;
        gfx_mask_i = m;
        gfx_addr_i = a;
        gfx_data_i = d;
        forever begin
            @(negedge clk);
            if (gfx_grant_o) break;
            waited++;
            if (waited > 500) break;
        end
        if (gfx_grant_o) begin
            if (wr) ref_mem[a] = merge(ref_mem[a], d, m);
            else exp_gfx.push_back(ref_mem[a]);
        end else begin
            fail_now("gfx_grant_timeout");
        end
        @(posedge clk);
        #1;
        gfx_sel_i = 1'b0;
    endtask

    task automatic disp_start(input logic [15:0] a, input logic [11:0] l);
        logic [15:0] ai;
        exp_disp.delete();
        exp_daddr.delete();
        for (int i = 0; i < int'(l); i++) begin
            ai = a + 16'(i);
            exp_daddr.push_back(ai);
            exp_disp.push_back(ref_mem[ai]);
        end
        disp_start_i = 1'b1;
        disp_addr_i  = a;
        disp_len_i   = l;
        @(posedge clk);
        #1;
        disp_start_i = 1'b0;
    endtask

    task automatic pop_words(input int n, input int pct, output int cyc);
        int got;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 2000) begin
            disp_rd_i = !disp_empty_o && (int'($urandom_range(99)) < pct);
            if (disp_rd_i) got++;
            @(posedge clk);
            #1;
            cyc++;
        end
        disp_rd_i = 1'b0;
        if (got < n) fail_now("pop_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1, w2, cyc;
        logic [15:0] d0;
        logic [15:0] v;

        reset_i = 1'b1;
        disp_start_i = 1'b0; disp_addr_i = '0; disp_len_i = '0; disp_rd_i = 1'b0;
        gfx_sel_i = 1'b0; gfx_wr_i = 1'b0; gfx_mask_i = 4'hF; gfx_addr_i = '0; gfx_data_i = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16'h0040] = 16'h0ABC;
        ref_mem[16'h0040] = 16'h0ABC;

        wait_cycles(3);
        reset_i = 1'b0;
        wait_cycles(1);
        check("rst_empty", 32'(disp_empty_o), 32'd1);
        check("rst_underrun", 32'(disp_underrun_o), 32'd0);
        check("rst_disp_data", 32'(disp_data_o), 32'd0);
        check("rst_grant", 32'(gfx_grant_o), 32'd0);
        check("rst_rvalid", 32'(gfx_rvalid_o), 32'd0);
        check("rst_gfx_data", 32'(gfx_data_o), 32'd0);
        check("rst_vram_sel", 32'(vram_sel_o), 32'd0);
        check("rst_vram_wr", 32'(vram_wr_o), 32'd0);
        check("rst_vram_mask", 32'(vram_mask_o), 32'hF);

        // Plain 8-word burst from address 0
        disp_start(16'h0000, 12'd8);
        wait_cycles(1);
        check("empty_1_after_start", 32'(disp_empty_o), 32'd1);
        wait_cycles(1);
        check("empty_2_after_start", 32'(disp_empty_o), 32'd0);
        wait_cycles(10);
        check("burst8_all_issued", 32'(exp_daddr.size()), 32'd0);
        pop_words(8, 100, cyc);
        check("burst8_drained", 32'(disp_empty_o), 32'd1);

        // Graphite read with fetch idle
        gfx_req(1'b0, 4'hF, 16'h0040, 16'h0000, w0);
        check("gfx_read_same_cycle_grant", 32'(w0), 32'd0);
        check("gfx_read_rvalid", 32'(gfx_rvalid_o), 32'd1);
        check("gfx_read_data", 32'(gfx_data_o), 32'h0ABC);
        wait_cycles(1);
        check("gfx_read_rvalid_single", 32'(gfx_rvalid_o), 32'd0);

        // Low-watermark preemption with graphite held
        fork
            disp_start(16'h3000, 12'd32);
            begin
                gfx_req(1'b0, 4'hF, 16'h4000, 16'h0000, w0);
                gfx_req(1'b0, 4'hF, 16'h4000, 16'h0000, w1);
                gfx_req(1'b0, 4'hF, 16'h4001, 16'h0000, w2);
            end
        join
        check("prio_grant_on_start", 32'(w0), 32'd0);
        check("prio_disp_wins_to_wm", 32'(w1), 32'd4);
        check("prio_gfx_after_wm", 32'(w2), 32'd0);
        pop_words(32, 70, cyc);

        // Address wrap at the top of the space
        disp_start(16'hFFFE, 12'd4);
        wait_cycles(8);
        check("wrap_all_issued", 32'(exp_daddr.size()), 32'd0);
        wait_cycles(5);
        pop_words(4, 100, cyc);

        // Zero-length burst stays idle
        disp_start(16'h1234, 12'd0);
        wait_cycles(5);
        check("len0_empty", 32'(disp_empty_o), 32'd1);

        // Restart mid-burst with a return in flight
        disp_start(16'h1000, 12'd16);
        wait_cycles(2);
        disp_start(16'h2000, 12'd8);
        wait_cycles(20);
        pop_words(8, 100, cyc);
        check("restart_only_new", 32'(disp_empty_o), 32'd1);
        check("restart_all_popped", 32'(exp_disp.size()), 32'd0);

        // Underrun is sticky until the next start
        d0 = disp_data_o;
        disp_rd_i = 1'b1;
        wait_cycles(1);
        disp_rd_i = 1'b0;
        check("underrun_set", 32'(disp_underrun_o), 32'd1);
        check("underrun_data_hold", 32'(disp_data_o), 32'(d0));
        wait_cycles(5);
        check("underrun_sticky", 32'(disp_underrun_o), 32'd1);
        disp_start(16'h2100, 12'd2);
        check("underrun_cleared", 32'(disp_underrun_o), 32'd0);
        wait_cycles(6);
        pop_words(2, 100, cyc);

        // Long burst with continuous graphite writes and a pop every cycle
        fork
            begin
                disp_start(16'h0800, 12'd64);
                wait_cycles(8);
                pop_words(64, 100, cyc);
                check("stream_no_stall", 32'(cyc), 32'd64);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    gfx_req(1'b1, 4'(1 + $urandom_range(14)), 16'h4000 + 16'($urandom_range(255)),
                            16'($urandom), w0);
                end
            end
        join
        check("stream_no_underrun", 32'(disp_underrun_o), 32'd0);

        // Randomized traffic on both sides
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    gfx_req(1'($urandom_range(1)), 4'($urandom_range(15)),
                            16'h4000 + 16'($urandom_range(255)), 16'($urandom), w0);
                    wait_cycles(int'($urandom_range(3)));
                end
            end
            begin
                for (int b = 0; b < 4; b++) begin
                    disp_start(16'($urandom_range(16'h3F00)), 12'($urandom_range(40, 1)));
                    pop_words(exp_disp.size(), 60, cyc);
                end
            end
        join
        check("random_no_underrun", 32'(disp_underrun_o), 32'd0);

        // Reset in the middle of a burst
        disp_start(16'h1800, 12'd16);
        wait_cycles(3);
        reset_i = 1'b1;
        exp_disp.delete();
        exp_daddr.delete();
        exp_gfx.delete();
        wait_cycles(2);
        reset_i = 1'b0;
        wait_cycles(1);
        check("midrst_empty", 32'(disp_empty_o), 32'd1);
        check("midrst_rvalid", 32'(gfx_rvalid_o), 32'd0);
        wait_cycles(5);
        check("midrst_no_issue", 32'(vram_sel_o), 32'd0);

        // Every graphite write landed where it was aimed
        wait_cycles(3);
        for (int a = 16'h4000; a < 16'h4100; a++) begin
            if (mem[a] !== ref_mem[a]) check("ram_word", 32'(mem[a]), 32'(ref_mem[a]));
            else n_vec++;
        end
        check("gfx_reads_returned", 32'(exp_gfx.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
